// File: rtl/traffic_display_driver.sv
// traffic_display_driver
//   Receives the traffic FSM's light state and countdown, converts the
//   countdown to two BCD digits with a sequential double-dabble engine,
//   scans a 2-digit multiplexed 7-segment display and drives three lamps.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   led[1:0]    light state: 00 red, 01 green, 10 yellow, 11 invalid
//   timer_value remaining seconds, 0..63
//   seg[6:0]    segment drive, active-high, bit0=a .. bit6=g
//   dig_en[1:0] one-hot digit enable: 01 ones, 10 tens
//   lamp_red / lamp_yellow / lamp_green  discrete lamp outputs
//   bcd_valid   one-cycle pulse when the display registers take a new value
//
// Parameters
//   SCAN_DIV    clocks each digit stays enabled (>= 2)
//   BLINK_DIV   half-period of the fault blink (FAULT_BLINK_EN only)
//
// Build option
//   FAULT_BLINK_EN  when defined, led=11 blinks the yellow lamp and shows
//                   a dash in both digits; otherwise led=11 darkens the lamps.
module traffic_display_driver #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] led,
  input  logic [5:0] timer_value,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       bcd_valid
);

  // Scan and blink counters share one width so both fit.
  localparam int CNT_W = $clog2((SCAN_DIV > BLINK_DIV) ? SCAN_DIV : BLINK_DIV);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       led_q;
  logic [5:0]       t_q;
  logic [5:0]       last_conv;
  logic [2:0]       shift_cnt;
  logic [13:0]      sr;
  logic [3:0]       tens_q, ones_q;
  logic [CNT_W-1:0] scan_cnt;
  logic             scan_wrap;
  logic [1:0]       dig_nxt;
  logic [6:0]       seg_d;

  // One double-dabble step: {tens, ones, binary} adjust-then-shift.
  function automatic logic [13:0] dabble_step(input logic [13:0] v);
    logic [13:0] a;
    a = v;
    if (a[9:6]   >= 4'd5) a[9:6]   = a[9:6]   + 4'd3;
    if (a[13:10] >= 4'd5) a[13:10] = a[13:10] + 4'd3;
    return {a[12:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b0111111;
      4'd1:    seg_encode = 7'b0000110;
      4'd2:    seg_encode = 7'b1011011;
      4'd3:    seg_encode = 7'b1001111;
      4'd4:    seg_encode = 7'b1100110;
      4'd5:    seg_encode = 7'b1101101;
      4'd6:    seg_encode = 7'b1111101;
      4'd7:    seg_encode = 7'b0000111;
      4'd8:    seg_encode = 7'b1111111;
      4'd9:    seg_encode = 7'b1101111;
      default: seg_encode = 7'b0000000;
    endcase
  endfunction

  // ---- input stage: free-running capture, kept live through reset ----
  always_ff @(posedge clk) begin
    led_q <= led;
    t_q   <= timer_value;
  end

  // ---- conversion FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (t_q != last_conv) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (shift_cnt == 3'd5) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_conv <= 6'd0;
      shift_cnt <= 3'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state_q)
        LOAD: begin
          last_conv <= t_q;
          shift_cnt <= 3'd0;
        end
        SHIFT: shift_cnt <= shift_cnt + 3'd1;
        DONE: begin
          tens_q    <= sr[13:10];
          ones_q    <= sr[9:6];
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Shift register is pure data; it is always loaded before use.
  always_ff @(posedge clk) begin
    case (state_q)
      LOAD:    sr <= {8'd0, t_q};
      SHIFT:   sr <= dabble_step(sr);
      default: ;
    endcase
  end

`ifdef FAULT_BLINK_EN
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_ph;

  // Phase 0 = lamp on, so the first fault cycle shows yellow lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (led_q == 2'b11) begin
      if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end else begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end
  end
`endif

  // ---- lamp stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_red    <= 1'b0;
      lamp_yellow <= 1'b0;
      lamp_green  <= 1'b0;
    end else begin
      lamp_red    <= (led_q == 2'b00);
      lamp_green  <= (led_q == 2'b01);
`ifdef FAULT_BLINK_EN
      lamp_yellow <= (led_q == 2'b10) | ((led_q == 2'b11) & ~blink_ph);
`else
      lamp_yellow <= (led_q == 2'b10);
`endif
    end
  end

  // ---- scan stage: seg follows the digit that dig_en selects next ----
  assign scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  assign dig_nxt   = scan_wrap ? ~dig_en : dig_en;

  always_comb begin
    seg_d = seg_encode(ones_q);
    if (dig_nxt[1]) seg_d = (tens_q == 4'd0) ? 7'b0000000 : seg_encode(tens_q);
`ifdef FAULT_BLINK_EN
    if (led_q == 2'b11) seg_d = 7'b1000000;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_en   <= 2'b01;
      seg      <= 7'b0000000;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + CNT_W'(1);
      dig_en   <= dig_nxt;
      seg      <= seg_d;
    end
  end

endmodule

// File: tb/tb_traffic_display_driver.sv
module tb_traffic_display_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] led;
  logic [5:0] timer_value;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       lamp_red, lamp_yellow, lamp_green, bcd_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0] sb[$];
  logic [6:0]  seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

  traffic_display_driver #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .led(led), .timer_value(timer_value),
    .seg(seg), .dig_en(dig_en), .lamp_red(lamp_red), .lamp_yellow(lamp_yellow),
    .lamp_green(lamp_green), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected {tens_seg, ones_seg} from decimal arithmetic, tens blanked at 0.
  function automatic logic [13:0] exp_disp(input int v);
    int t, o;
    t = v / 10;
    o = v % 10;
    return {(t == 0) ? 7'b0000000 : seg_tab[t], seg_tab[o]};
  endfunction

  task automatic drive_t(input int v);
    timer_value = 6'(v);
    sb.push_back(exp_disp(v));
  endtask

  task automatic check_display(input string tag, input logic [6:0] et, input logic [6:0] eo);
    logic [6:0] ts, os;
    ts = 7'h7f;
    os = 7'h7f;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dig_en == 2'b10) ts = seg;
      else if (dig_en == 2'b01) os = seg;
    end
    chk({tag, "_tens"}, {9'd0, ts}, {9'd0, et});
    chk({tag, "_ones"}, {9'd0, os}, {9'd0, eo});
  endtask

  // Waits for bcd_valid (bounded), pops the scoreboard and checks the display.
  task automatic pop_check(input string tag, output int cyc);
    logic [13:0] e;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bcd_valid && cyc < 40);
    chk({tag, "_valid"}, {15'd0, bcd_valid}, 16'd1);
    chk({tag, "_sb"}, (sb.size() > 0) ? 16'd1 : 16'd0, 16'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '1;
    check_display(tag, e[13:7], e[6:0]);
  endtask

  task automatic lamps_chk(input string tag, input logic [2:0] ryg);
    chk(tag, {13'd0, lamp_red, lamp_yellow, lamp_green}, {13'd0, ryg});
  endtask

  initial begin
    int cyc;
    int run;
    logic seen_chg;
    logic any_valid;
    logic [1:0] prev;
    logic [1:0] led_seq [4];
    logic [2:0] lamp_exp [4];

    led_seq  = '{2'b01, 2'b10, 2'b00, 2'b11};
    lamp_exp = '{3'b001, 3'b010, 3'b100, 3'b000};

    rst_n = 1'b0;
    led = 2'b00;
    timer_value = 6'd0;

    // Reset state
    @(negedge clk);
    chk("rst_seg", {9'd0, seg}, 16'd0);
    chk("rst_dig_en", {14'd0, dig_en}, 16'd1);
    lamps_chk("rst_lamps", 3'b000);
    chk("rst_valid", {15'd0, bcd_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: red lamp, " 0", regular scan, no conversion
    @(negedge clk);
    @(negedge clk);
    lamps_chk("red_after_rst", 3'b100);
    prev = dig_en;
    run = 1;
    seen_chg = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_valid |= bcd_valid;
      if (dig_en != prev) begin
        if (seen_chg) chk("scan_period", 16'(run), 16'd4);
        seen_chg = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev = dig_en;
    end
    chk("no_valid_idle", {15'd0, any_valid}, 16'd0);
    check_display("init", 7'b0000000, 7'b0111111);

    // 0 -> 37 with latency measurement
    drive_t(37);
    pop_check("v37", cyc);
    chk("latency37", 16'(cyc), 16'd10);

    // 63, then 9 (tens blank), then 0, then wrap 0 -> 63
    drive_t(63);
    pop_check("v63", cyc);
    drive_t(9);
    pop_check("v9", cyc);
    drive_t(0);
    pop_check("v0", cyc);
    drive_t(63);
    pop_check("v63b", cyc);

    // Change during a running conversion: both values are shown in turn
    drive_t(12);
    repeat (3) @(negedge clk);
    drive_t(20);
    pop_check("v12", cyc);
    pop_check("v20", cyc);

    // Lamp decode
    for (int i = 0; i < 4; i++) begin
`ifdef FAULT_BLINK_EN
      if (led_seq[i] == 2'b11) break;
`endif
      led = led_seq[i];
      @(negedge clk);
      @(negedge clk);
      lamps_chk($sformatf("lamp_led%0d", led_seq[i]), lamp_exp[i]);
    end

`ifdef FAULT_BLINK_EN
    led = 2'b11;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("blink_%0d", k), {15'd0, lamp_yellow}, ((k / 8) % 2 == 0) ? 16'd1 : 16'd0);
      chk("fault_dash", {9'd0, seg}, 16'h40);
      chk("fault_rg", {14'd0, lamp_red, lamp_green}, 16'd0);
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    led = 2'b01;
    @(negedge clk);
    @(negedge clk);
    lamps_chk("fault_exit_green", 3'b001);
    check_display("fault_exit", seg_tab[2], seg_tab[0]);
`endif

    led = 2'b00;

    // Reset asserted during SHIFT, then a fresh conversion afterwards
    drive_t(45);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", {9'd0, seg}, 16'd0);
    chk("midrst_dig_en", {14'd0, dig_en}, 16'd1);
    lamps_chk("midrst_lamps", 3'b000);
    chk("midrst_valid", {15'd0, bcd_valid}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pop_check("v45", cyc);
    lamps_chk("red_after_midrst", 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
